// File: rtl/if_stage.sv
// Instruction-fetch stage: drives a single-outstanding instruction-memory port and
// registers the IF/ID pair, with a one-entry skid for responses that land during a stall.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        Br_taken,
  input  logic [31:0] Br_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instruction,
  output logic [31:0] PC,
  output logic        IF_valid
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]  state;
  logic [31:0] pc, req_addr;
  logic [31:0] skid_instr, skid_pc;
  logic        skid_valid;

  logic [31:0] target, next_addr;
  assign target    = Br_addr & ~32'h3;
  assign next_addr = req_addr + 32'd4;

  // The request is a pure function of state so the address stays stable until ready.
  assign imem_req  = (state == FETCH) || (state == DRAIN);
  assign imem_addr = req_addr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      req_addr    <= RESET_PC;
      Instruction <= 32'd0;
      PC          <= 32'd0;
      IF_valid    <= 1'b0;
      skid_instr  <= 32'd0;
      skid_pc     <= 32'd0;
      skid_valid  <= 1'b0;
    end else if (Br_taken) begin
      Instruction <= 32'd0;
      IF_valid    <= 1'b0;
      skid_valid  <= 1'b0;
      pc          <= target;
      case (state)
        FETCH: begin
          if (imem_ready) req_addr <= target;
          else            state    <= DRAIN;
        end
        // A redirect while draining only moves pc, unless the drain completes now.
        DRAIN: begin
          if (imem_ready) begin
            req_addr <= target;
            state    <= FETCH;
          end
        end
        default: begin
          req_addr <= target;
          state    <= FETCH;
        end
      endcase
    end else begin
      case (state)
        IDLE: begin
          req_addr <= pc;
          state    <= FETCH;
        end
        FETCH: begin
          if (imem_ready) begin
            pc <= next_addr;
            if (freeze) begin
              skid_instr <= imem_rdata;
              skid_pc    <= next_addr;
              skid_valid <= 1'b1;
              state      <= HOLD;
            end else begin
              Instruction <= imem_rdata;
              PC          <= next_addr;
              IF_valid    <= 1'b1;
              req_addr    <= next_addr;
            end
          end
        end
        HOLD: begin
          if (!freeze) begin
            Instruction <= skid_instr;
            PC          <= skid_pc;
            IF_valid    <= skid_valid;
            skid_valid  <= 1'b0;
            req_addr    <= pc;
            state       <= FETCH;
          end
        end
        default: begin
          // Data for the flushed request is dropped; refetch from the redirect target.
          if (imem_ready) begin
            req_addr <= pc;
            state    <= FETCH;
          end
        end
      endcase
    end
  end

endmodule
